// File: rtl/p256_fast_reducer_if.sv
// Handshake/data bundle between the product source and the P-256 reducer.
interface p256_fast_reducer_if #(
    parameter int DATA_W = 256
);
    logic              start;
    logic [DATA_W-1:0] prod_low;
    logic [DATA_W-1:0] prod_high;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] out;

    modport master (
        output start, prod_low, prod_high,
        input  busy, done, out
    );

    modport slave (
        input  start, prod_low, prod_high,
        output busy, done, out
    );
endinterface

// File: rtl/p256_fast_reducer.sv
// Sequential P-256 fast reduction of a 512-bit product using one shared
// add/sub datapath: 11 accumulate steps, then +/-p corrections until in range.
module p256_fast_reducer #(
    parameter int DATA_W = 256,
    parameter int ACC_W  = 260
) (
    input  logic                 clk,
    input  logic                 rst_n,
    p256_fast_reducer_if.slave   bus
);
    localparam logic [DATA_W-1:0] P =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    localparam logic [ACC_W-1:0] P_EXT = ACC_W'(P);

    typedef enum logic [1:0] {IDLE, ACC, FIX} state_e;

    state_e              state_q, state_d;
    logic [2*DATA_W-1:0] c_q, c_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [3:0]          step_q, step_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [15:0][31:0]   cw;
    logic [DATA_W-1:0]   term;
    logic                term_sub;
    logic [ACC_W-1:0]    op_a, op_b, sum;
    logic                op_sub;
    logic                acc_neg, acc_ge_p, acc_ok;

    assign cw = c_q;

    // Word-recombination terms, selected by the accumulate step
    always_comb begin
        term     = '0;
        term_sub = 1'b0;
        unique case (step_q)
            4'd0: term = {cw[7], cw[6], cw[5], cw[4],
                          cw[3], cw[2], cw[1], cw[0]};
            4'd1, 4'd2: term = {cw[15], cw[14], cw[13], cw[12],
                                cw[11], 32'd0, 32'd0, 32'd0};
            4'd3, 4'd4: term = {32'd0, cw[15], cw[14], cw[13],
                                cw[12], 32'd0, 32'd0, 32'd0};
            4'd5: term = {cw[15], cw[14], 32'd0, 32'd0,
                          32'd0, cw[10], cw[9], cw[8]};
            4'd6: term = {cw[8], cw[13], cw[15], cw[14],
                          cw[13], cw[11], cw[10], cw[9]};
            4'd7: begin
                term = {cw[10], cw[8], 32'd0, 32'd0,
                        32'd0, cw[13], cw[12], cw[11]};
                term_sub = 1'b1;
            end
            4'd8: begin
                term = {cw[11], cw[9], 32'd0, 32'd0,
                        cw[15], cw[14], cw[13], cw[12]};
                term_sub = 1'b1;
            end
            4'd9: begin
                term = {cw[12], 32'd0, cw[10], cw[9],
                        cw[8], cw[15], cw[14], cw[13]};
                term_sub = 1'b1;
            end
            4'd10: begin
                term = {cw[13], 32'd0, cw[11], cw[10],
                        cw[9], 32'd0, cw[15], cw[14]};
                term_sub = 1'b1;
            end
            default: term = '0;
        endcase
    end

    assign acc_neg  = acc_q[ACC_W-1];
    assign acc_ge_p = !acc_neg && (acc_q >= P_EXT);
    assign acc_ok   = !acc_neg && !acc_ge_p;

    // Single shared adder: term in ACC, modulus in FIX
    always_comb begin
        op_a   = acc_q;
        op_b   = P_EXT;
        op_sub = !acc_neg;
        if (state_q == ACC) begin
            op_a   = (step_q == 4'd0) ? '0 : acc_q;
            op_b   = ACC_W'(term);
            op_sub = term_sub;
        end
        sum = op_sub ? (op_a - op_b) : (op_a + op_b);
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        acc_d   = acc_q;
        step_d  = step_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    c_d     = {bus.prod_high, bus.prod_low};
                    step_d  = 4'd0;
                    busy_d  = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d  = sum;
                step_d = step_q + 4'd1;
                if (step_q == 4'd10) begin
                    step_d  = 4'd0;
                    state_d = FIX;
                end
            end
            FIX: begin
                unique case (1'b1)
                    acc_neg, acc_ge_p: acc_d = sum;
                    acc_ok: begin
                        out_d   = acc_q[DATA_W-1:0];
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                    default: acc_d = acc_q;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;
endmodule

// File: tb/tb_p256_fast_reducer.sv
// Scoreboard bench for the P-256 reducer: directed vectors queued at issue,
// a negedge monitor pops and checks result and latency on each done.
module tb_p256_fast_reducer;
    localparam logic [255:0] P =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    typedef struct {
        logic [255:0] res;
        int           lat;
        int           sc;
        string        nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    p256_fast_reducer_if bus ();

    p256_fast_reducer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, req);
    endtask

    exp_t me;
    int   ml;
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 required none");
            end else begin
                me = sb.pop_front();
                ml = cyc - me.sc;
                check({me.nm, "_out"}, bus.out, me.res);
                check({me.nm, "_busy_at_done"}, 256'(bus.busy), 256'd0);
                if (me.lat >= 0) begin
                    check({me.nm, "_latency"}, 256'(ml), 256'(me.lat));
                end else begin
                    n_checks++;
                    if (ml >= 12 && ml <= 19) n_pass++;
                    else $display("FAIL %s_latency: got %0d required 12..19",
                                  me.nm, ml);
                end
            end
        end
    end

    task automatic issue(input logic [511:0] c, input logic [255:0] res,
                         input int lat, input string nm, input int poke);
        exp_t e;
        int   t;
        t = 0;
        while ((bus.busy || bus.done) && t < 50) begin
            @(negedge clk);
            t++;
        end
        bus.prod_high = c[511:256];
        bus.prod_low  = c[255:0];
        bus.start     = 1'b1;
        e.res = res;
        e.lat = lat;
        e.sc  = cyc + 1;
        e.nm  = nm;
        sb.push_back(e);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.prod_high = ~c[511:256];
        bus.prod_low  = ~c[255:0];
        check({nm, "_busy"}, 256'(bus.busy), 256'd1);
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            bus.start = (t == poke);
            @(negedge clk);
            t++;
        end
        bus.start = 1'b0;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL %s_timeout: got no done required done", nm);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] c;
        logic [511:0] pm1;
        logic [511:0] r;
        int           sc;
        bus.start     = 1'b0;
        bus.prod_low  = '0;
        bus.prod_high = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 256'(bus.busy), 256'd0);
        check("rst_done", 256'(bus.done), 256'd0);
        check("rst_out", bus.out, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(512'd0, 256'd0, 12, "zero", -1);
        issue(512'd5, 256'd5, 12, "five", -1);
        issue({256'd0, P}, 256'd0, 13, "p", -1);
        issue({256'd0, {256{1'b1}}},
              256'h00000000FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF000000000000000000000000,
              -1, "all1_low", -1);
        pm1 = {256'd0, P - 256'd1};
        issue(pm1 * pm1, 256'd1, -1, "pm1_sq", -1);

        // start during ACC must be ignored
        issue(512'd7, 256'd7, 12, "ignored_start", 3);
        repeat (25) @(negedge clk);

        // reset while in FIX
        bus.prod_high = '0;
        bus.prod_low  = P;
        bus.start     = 1'b1;
        sc = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < sc + 12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 256'(bus.busy), 256'd0);
        check("abort_done", 256'(bus.done), 256'd0);
        check("abort_out", bus.out, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        issue({256'd0, {256{1'b1}}},
              256'h00000000FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF000000000000000000000000,
              -1, "after_rst", -1);

        c = {512{1'b1}};
        r = c % {256'd0, P};
        issue(c, r[255:0], -1, "max512", -1);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 16; j++) c[32*j +: 32] = $urandom;
            r = c % {256'd0, P};
            issue(c, r[255:0], -1, $sformatf("rnd%0d", i), -1);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
